// File: rtl/ram_stream_writer.sv
// Packs a 16-bit valid/ready stream into 80-bit RAM words, or zero-fills a range,
// driving the RAM write port at consecutive (wrapping) addresses from a base.
module ram_stream_writer #(
  parameter int unsigned DATA_W = 80,
  parameter int unsigned IN_W   = 16,
  parameter int unsigned ADDR_W = 15
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  input  logic              start_load,
  input  logic              start_clear,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   num_words,
  input  logic              in_valid,
  input  logic [IN_W-1:0]   in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] wraddress,
  output logic [DATA_W-1:0] data,
  output logic              wren,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   words_written
);

  localparam int unsigned BEATS  = DATA_W / IN_W;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [2:0] {StIdle, StLoad, StClear, StLast, StDone} state_e;

  state_e              r_state, w_state;
  logic [ADDR_W-1:0]   r_base, w_base;
  logic [ADDR_W:0]     r_num, w_num;
  logic [ADDR_W:0]     r_ww, w_ww;
  logic [BEAT_W-1:0]   r_beat, w_beat;
  logic [DATA_W-1:0]   r_pack, w_pack;
  logic [ADDR_W-1:0]   r_wraddress, w_wraddress;
  logic [DATA_W-1:0]   r_data, w_data;
  logic                r_wren, w_wren;
  logic                r_busy, w_busy;
  logic                r_done, w_done;

  logic [ADDR_W:0]     w_count_inc;
  logic                w_last_word;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_word;

  always_comb begin
    w_count_inc = r_ww + {{ADDR_W{1'b0}}, 1'b1};
    w_last_word = (w_count_inc == r_num);
    // Carry out of the address adder is dropped so writes wrap to 0.
    w_addr      = r_base + r_ww[ADDR_W-1:0];
    w_word      = r_pack;
    w_word[r_beat*IN_W +: IN_W] = in_data;

    w_state     = r_state;
    w_base      = r_base;
    w_num       = r_num;
    w_ww        = r_ww;
    w_beat      = r_beat;
    w_pack      = r_pack;
    w_wraddress = r_wraddress;
    w_data      = r_data;
    w_wren      = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (start_clear || start_load) begin
          w_base = base_addr;
          w_num  = num_words;
          w_ww   = '0;
          w_beat = '0;
          w_pack = '0;
          if (num_words == '0) begin
            w_state = StDone;
          end else if (start_clear) begin
            // First clear write is issued on the start edge itself.
            w_wren      = 1'b1;
            w_data      = '0;
            w_wraddress = base_addr;
            w_ww        = {{ADDR_W{1'b0}}, 1'b1};
            w_state     = (num_words == {{ADDR_W{1'b0}}, 1'b1}) ? StLast : StClear;
          end else begin
            w_state = StLoad;
          end
        end
      end
      StLoad: begin
        if (in_valid) begin
          if (r_beat == BEAT_W'(BEATS - 1)) begin
            w_wren      = 1'b1;
            w_data      = w_word;
            w_wraddress = w_addr;
            w_ww        = w_count_inc;
            w_beat      = '0;
            w_pack      = '0;
            if (w_last_word) w_state = StLast;
          end else begin
            w_pack = w_word;
            w_beat = r_beat + BEAT_W'(1);
          end
        end
      end
      StClear: begin
        w_wren      = 1'b1;
        w_data      = '0;
        w_wraddress = w_addr;
        w_ww        = w_count_inc;
        if (w_last_word) w_state = StLast;
      end
      StLast:  w_state = StDone;
      StDone:  w_state = StIdle;
      default: w_state = StIdle;
    endcase

    w_busy = (w_state == StLoad) || (w_state == StClear) || (w_state == StLast);
    w_done = (w_state == StDone);
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= StIdle;
      r_base      <= '0;
      r_num       <= '0;
      r_ww        <= '0;
      r_beat      <= '0;
      r_pack      <= '0;
      r_wraddress <= '0;
      r_data      <= '0;
      r_wren      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_base      <= w_base;
      r_num       <= w_num;
      r_ww        <= w_ww;
      r_beat      <= w_beat;
      r_pack      <= w_pack;
      r_wraddress <= w_wraddress;
      r_data      <= w_data;
      r_wren      <= w_wren;
      r_busy      <= w_busy;
      r_done      <= w_done;
    end
  end

  assign in_ready      = (r_state == StLoad);
  assign wraddress     = r_wraddress;
  assign data          = r_data;
  assign wren          = r_wren;
  assign busy          = r_busy;
  assign done          = r_done;
  assign words_written = r_ww;

endmodule

// File: doc/ram_stream_writer.md
Name: ram_stream_writer

Overview:
- Write-side companion to the dual-port body-state RAM (80-bit words, 15-bit address) used by the n-body datapath.
- Packs a 16-bit valid/ready input stream into 80-bit words and drives the RAM write port (wraddress/data/wren) at consecutive addresses from a programmable base.
- Also provides a zero-fill (clear) mode, so the RAM can be initialised without a memory init file before readback on the HEX displays.

Parameters:
- DATA_W, 80, RAM word width; must be an integer multiple of IN_W.
- IN_W, 16, input stream beat width.
- ADDR_W, 15, RAM address width.
- BEATS, DATA_W/IN_W (5), beats per RAM word; derived, not overridden.

Ports:
- CLOCK_50  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset (driven from KEY[0] at top level).
- start_load  in  1  one-cycle pulse: begin stream load.
- start_clear  in  1  one-cycle pulse: begin zero-fill.
- base_addr  in  ADDR_W  first RAM address; sampled on an accepted start.
- num_words  in  ADDR_W+1  number of 80-bit words to write; sampled on an accepted start.
- in_valid  in  1  input beat valid.
- in_data  in  IN_W  input beat.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- wraddress  out  ADDR_W  RAM write address.
- data  out  DATA_W  RAM write data.
- wren  out  1  RAM write enable.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- words_written  out  ADDR_W+1  words written in the current or last operation.

Behaviour:
- Reset: all outputs are 0; state is IDLE; beat counter and partial word are cleared.
- Reset asserted mid-operation aborts immediately. The partial word is discarded and no further wren is issued.
- States:
  - IDLE: starts are accepted only here.
  - start_clear wins if both start_clear and start_load are high in the same cycle → CLEAR.
  - start_load → LOAD.
  - On an accepted start, base_addr and num_words are latched and words_written is cleared.
  - A start with num_words=0 → DONE directly; no wren is issued.
  - Starts while busy are ignored.
- busy is registered: high from the cycle after an accepted start through the cycle of the final wren; low in IDLE and DONE.
- LOAD:
  - in_ready=1 throughout LOAD, 0 in all other states.
  - Beat k (0..BEATS-1) of a word fills data bits [k*IN_W +: IN_W]. The first beat lands in [15:0].
  - When beat BEATS-1 is accepted at edge t, the outputs registered at that edge are wren=1, data=packed word, wraddress=(base+i) mod 2^ADDR_W. wren is therefore high in cycle t+1, for exactly one cycle.
  - words_written increments with each wren.
  - No stall is required: the RAM write port accepts every cycle, so back-to-back words are written at full rate.
  - After word num_words-1 is written → DONE.
  - in_ready drops in the cycle after the final beat is accepted.
- CLEAR:
  - wren=1 with data=0 on each of num_words consecutive cycles; the first wren is in the cycle after the accepted start.
  - Address sequence is base, base+1, …; in_data is ignored.
- Address wrap: wraddress wraps from 2^ADDR_W-1 to 0 with no error. If num_words = 2^ADDR_W, every location is written exactly once.
- DONE: done=1 for exactly one cycle, the cycle after the final wren (or the cycle after the start when num_words=0); then → IDLE. words_written holds until the next accepted start.
- wren is 0 at all times except the write cycles described above. data and wraddress hold their last values when wren=0.
- Width: the address adder is ADDR_W bits and drops the carry. The word count comparison uses ADDR_W+1 bits.

Test Plan:
- Reset mid-load: assert reset_n=0 after 3 beats → in the same cycle busy=0, in_ready=0, wren=0; after release, a new load with base=0, num_words=1 writes a word with no stale beats.
- Single load: base=0x0010, num_words=1, beats 0x1111, 0x2222, 0x3333, 0x4444, 0x5555 back-to-back → one wren the cycle after the 5th beat, wraddress=0x0010, data=0x5555_4444_3333_2222_1111; done the following cycle; words_written=1.
- Gapped stream: num_words=2, in_valid toggled every other cycle → exactly 2 wren pulses at addresses base and base+1, correct packing, no beat lost or duplicated.
- Wrap-around: base=0x7FFE, num_words=3 via CLEAR → wren on 3 consecutive cycles at 0x7FFE, 0x7FFF, 0x0000 with data=0; done on the 4th cycle; RAM readback at those addresses is 0.
- Zero count and priority: start_load with num_words=0 → done next cycle, no wren. Simultaneous start_load and start_clear → CLEAR runs and in_ready stays 0. A start_load pulsed during busy → ignored, and words_written is unaffected.
